// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode sequencer: FSM states, the
// buffered element record and the zero-means-one width handling.
package barcode_pkg;

  localparam int QUIET_W = 8;
  localparam int WIDTH_W = 4;

  // Quiet-zone length of zero skips the zone entirely.
  localparam logic [QUIET_W-1:0] QUIET_NONE = 8'd0;
  localparam logic [QUIET_W-1:0] QUIET_ONE  = 8'd1;

  // A requested width of zero is stretched to a single module.
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_TRAIL
  } state_t;

  typedef struct packed {
    logic               bar;
    logic [WIDTH_W-1:0] width;
    logic               last;
  } elem_t;

  function automatic logic [WIDTH_W-1:0] eff_width(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? WIDTH_ONE : w;
  endfunction

endpackage

// File: rtl/barcode_elem_fifo.sv
// Element buffer: power-of-two FIFO with wrap-bit pointers, synchronous
// flush, and push accepted while full when a pop happens in the same cycle.
module barcode_elem_fifo
  import barcode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  logic  push_i,
  input  elem_t din_i,
  input  logic  pop_i,
  output elem_t dout_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  elem_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; a flush discards everything buffered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone say which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/barcode_seq_ctrl.sv
// Barcode LED sequencer: buffers bar/space elements and plays a frame as
// leading quiet zone, elements, trailing quiet zone on a registered PWM line.
module barcode_seq_ctrl
  import barcode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PER_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] mod_period,
  input  logic [7:0]       quiet_mods,
  input  logic [3:0]       drive_code,
  input  logic             ir500_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bar,
  input  logic [3:0]       s_width,
  input  logic             s_last,
  output logic             barcode_pwm,
  output logic [3:0]       cbit_barcode,
  output logic             cbit_ir500,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [PER_W-1:0]     per_q, per_d;
  logic [QUIET_W-1:0]   qmods_q, qmods_d;
  logic [PER_W-1:0]     mod_cnt_q, mod_cnt_d;
  logic [WIDTH_W-1:0]   wid_cnt_q, wid_cnt_d;
  logic [QUIET_W-1:0]   qz_cnt_q, qz_cnt_d;
  logic                 last_q, last_d;
  logic                 uflag_q, uflag_d;
  logic                 pwm_q, pwm_d;
  logic [3:0]           cbit_q, cbit_d;
  logic                 ir_q, ir_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 under_q, under_d;
  logic                 alive_q;

  logic                 fifo_push, fifo_pop, fifo_flush;
  logic                 fifo_empty, fifo_full;
  elem_t                in_elem, head;
  logic [PER_W-1:0]     per_sel;
  logic [QUIET_W-1:0]   quiet_sel;
  logic                 next_elem, end_frame;

  assign in_elem   = '{bar: s_bar, width: s_width, last: s_last};
  // alive_q holds s_ready low from reset until the first clock edge.
  assign s_ready   = alive_q & en & ~fifo_full;
  assign fifo_push = s_valid & s_ready;

  barcode_elem_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (in_elem),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Next-state, counters and registered-output values for the frame FSM.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path infers a latch.
    state_d    = state_q;
    per_d      = per_q;
    qmods_d    = qmods_q;
    mod_cnt_d  = mod_cnt_q;
    wid_cnt_d  = wid_cnt_q;
    qz_cnt_d   = qz_cnt_q;
    last_d     = last_q;
    uflag_d    = uflag_q;
    pwm_d      = pwm_q;
    cbit_d     = cbit_q;
    ir_d       = ir_q;
    done_d     = 1'b0;
    under_d    = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    next_elem  = 1'b0;
    end_frame  = 1'b0;
    // In IDLE the frame is launching, so use the live inputs being latched.
    per_sel    = (state_q == ST_IDLE) ? ((mod_period == '0) ? PER_ONE : mod_period) : per_q;
    quiet_sel  = (state_q == ST_IDLE) ? quiet_mods : qmods_q;

    if (state_q != ST_IDLE && !en) begin
      state_d    = ST_IDLE;
      pwm_d      = 1'b0;
      cbit_d     = '0;
      ir_d       = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en && !fifo_empty) begin
            per_d   = per_sel;
            qmods_d = quiet_mods;
            cbit_d  = drive_code;
            ir_d    = ir500_mode;
            uflag_d = 1'b0;
            last_d  = 1'b0;
            if (quiet_mods == QUIET_NONE) begin
              next_elem = 1'b1;
            end else begin
              state_d   = ST_LEAD;
              pwm_d     = 1'b0;
              mod_cnt_d = per_sel - PER_ONE;
              qz_cnt_d  = quiet_mods - QUIET_ONE;
            end
          end
        end
        ST_LEAD, ST_TRAIL: begin
          if (mod_cnt_q != '0) begin
            mod_cnt_d = mod_cnt_q - PER_ONE;
          end else if (qz_cnt_q != '0) begin
            qz_cnt_d  = qz_cnt_q - QUIET_ONE;
            mod_cnt_d = per_q - PER_ONE;
          end else if (state_q == ST_LEAD) begin
            next_elem = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = ~uflag_q;
            cbit_d  = '0;
            ir_d    = 1'b0;
          end
        end
        ST_RUN: begin
          if (mod_cnt_q != '0) begin
            mod_cnt_d = mod_cnt_q - PER_ONE;
          end else if (wid_cnt_q != '0) begin
            wid_cnt_d = wid_cnt_q - WIDTH_ONE;
            mod_cnt_d = per_q - PER_ONE;
          end else if (last_q) begin
            end_frame = 1'b1;
          end else begin
            next_elem = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Element boundary: start the next element, or starve into the trailer.
    if (next_elem) begin
      if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        state_d   = ST_RUN;
        pwm_d     = head.bar;
        last_d    = head.last;
        wid_cnt_d = eff_width(head.width) - WIDTH_ONE;
        mod_cnt_d = per_sel - PER_ONE;
      end else begin
        under_d   = 1'b1;
        uflag_d   = 1'b1;
        end_frame = 1'b1;
      end
    end

    // Frame body finished: trailing quiet zone, or straight back to IDLE.
    if (end_frame) begin
      pwm_d = 1'b0;
      if (quiet_sel == QUIET_NONE) begin
        state_d = ST_IDLE;
        done_d  = ~uflag_d;
        cbit_d  = '0;
        ir_d    = 1'b0;
      end else begin
        state_d   = ST_TRAIL;
        mod_cnt_d = per_sel - PER_ONE;
        qz_cnt_d  = quiet_sel - QUIET_ONE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      per_q     <= PER_ONE;
      qmods_q   <= '0;
      mod_cnt_q <= '0;
      wid_cnt_q <= '0;
      qz_cnt_q  <= '0;
      last_q    <= 1'b0;
      uflag_q   <= 1'b0;
      pwm_q     <= 1'b0;
      cbit_q    <= '0;
      ir_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      qmods_q   <= qmods_d;
      mod_cnt_q <= mod_cnt_d;
      wid_cnt_q <= wid_cnt_d;
      qz_cnt_q  <= qz_cnt_d;
      last_q    <= last_d;
      uflag_q   <= uflag_d;
      pwm_q     <= pwm_d;
      cbit_q    <= cbit_d;
      ir_q      <= ir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      under_q   <= under_d;
      alive_q   <= 1'b1;
    end
  end

  assign barcode_pwm  = pwm_q;
  assign cbit_barcode = cbit_q;
  assign cbit_ir500   = ir_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun     = under_q;

endmodule
